sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port arbiter sharing the single SDRAM controller between the CPU load/store unit (port 0) and the video/DMA fetch unit (port 1). It arbitrates requests, registers the winning port's command onto the controller command bus, and issues a one-cycle start strobe. It then waits for completion, returns read data and an acknowledge to the owner, and flags a downstream hang with a watchdog counter.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles without `mem_done` before abort; range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request; held high with payload stable until the matching ack.
- len0 / len1  in  2  access type: 00 read32, 01 write8, 10 write16, 11 write32.
- addr0 / addr1  in  26  access address.
- wdata0 / wdata1  in  32  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read data; valid from the ack cycle until the next read by that port.
- mem_addr  out  26  registered command address to the controller.
- mem_wdata  out  32  registered write data.
- mem_wlen  out  2  registered access type.
- mem_start  out  1  one-cycle start strobe.
- mem_done  in  1  one-cycle completion pulse from the controller.
- mem_rdata  in  32  controller read data; valid in the `mem_done` cycle.
- busy  out  1  high in ISSUE and WAIT.
- owner  out  1  port of the current or last grant.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE.** The eligible set is req0&~ack0 and req1&~ack1. This masking stops the port just acked from re-winning on its still-high req.
  - If the set is non-empty: pick a winner, latch its addr/wdata/len into the mem_* registers, set owner, and go to ISSUE.
  - If the set is empty: stay in IDLE.
- **ISSUE.** Drive mem_start=1 for this cycle only, clear the watchdog counter, and go to WAIT.
- **WAIT.**
  - The counter increments each cycle.
  - On mem_done: if mem_wlen==00, capture mem_rdata into rdata[owner]. Pulse ack[owner] on the next cycle and go to IDLE.
  - Writes leave rdata unchanged.
- **Watchdog.** When the counter reaches TIMEOUT_CYCLES-1 without mem_done: set timeout_err, pulse ack[owner] with rdata unchanged, and go to IDLE.
  - mem_done in the terminal-count cycle counts as a normal completion; no error is flagged.
- mem_done is ignored in IDLE and ISSUE.
- mem_* registers hold their values after completion until the next grant.
- At most one ack is high per cycle. ack0 and ack1 are never simultaneous.
- **Reset values:** all outputs 0, state IDLE, counter 0, timeout_err 0, owner 0, round-robin pointer "last=1".
- **Reset mid-access:** the transaction is abandoned with no ack. The requester re-requests after reset.

## Timing
- In each cycle below, the named output is registered on the edge that starts that cycle; the state shown is the state in that cycle.
- Cycle 0: req seen in IDLE.
- Cycle 1: mem_* valid, mem_start=1 (ISSUE).
- Cycle 2 onward: WAIT. mem_done in cycle k gives ack in cycle k+1, with state IDLE in cycle k+1.
- Minimum request-to-ack latency is 3 cycles, with mem_done in cycle 2.
- Back-to-back: a new grant can be made in the ack cycle, so mem_start for the other port appears in cycle k+2.
- A requester deasserts req (or presents the next payload) in the cycle after it sees ack. It must not change the payload while req is high and unacked.

## Configuration
- SDRAM_ARB_RR_EN defined: round-robin.
  - On simultaneous eligible requests, the port ≠ last grant wins.
  - The last pointer updates at each grant.
- SDRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins.
  - The pointer logic is removed.
  - Port 1 can starve under continuous port 0 traffic.

## Test plan
- **Single read.** req0, len0=00, addr0=26'h0001234; mem_done at cycle 4 with mem_rdata=32'hCAFE0123.
  - Required: mem_start in cycle 1 with mem_addr=26'h0001234, ack0 in cycle 5, rdata0=32'hCAFE0123.
- **Single write.** req1, len1=11, wdata1=32'h12345678.
  - Required: mem_wlen=11, mem_wdata=32'h12345678; ack1 one cycle after mem_done; rdata1 unchanged.
- **Simultaneous requests, repeated 4 times, both ports held high.**
  - With SDRAM_ARB_RR_EN, grants alternate 0,1,0,1.
  - Without it, grants are 0,0,0,0 and ack1 never occurs.
- **Ack masking.** req0 held through ack0 with req1 low.
  - Required: no second grant to port 0 in the ack cycle. The next grant happens only if req0 is still high one cycle later.
- **Timeout.** TIMEOUT_CYCLES=8, mem_done never arrives.
  - Required: ack0 after 8 WAIT cycles, timeout_err=1 and stays set. A following request completes normally with timeout_err still 1.
- **Reset mid-WAIT.** Assert rst during WAIT.
  - Required: all outputs 0 immediately (asynchronous), no ack. After release, state is IDLE and a simultaneous request goes to port 0 first.

Source files
------------

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port SDRAM controller arbiter with watchdog
// Optional: define SDRAM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module sdram_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  len0,
    input  logic [1:0]  len1,
    input  logic [25:0] addr0,
    input  logic [25:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [25:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_wlen,
    output logic        mem_start,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner,
    output logic        timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [25:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_wlen_q, mem_wlen_d;
    logic        mem_start_q, mem_start_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        owner_q, owner_d;
    logic        terr_q, terr_d;
    logic        elig0, elig1, winner;

    // A port acked this cycle is masked so its still-high req cannot re-win.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

`ifdef SDRAM_ARB_RR_EN
    logic last_q, last_d;
    assign winner = (elig0 & elig1) ? ~last_q : elig1;
`else
    assign winner = ~elig0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wlen_d  = mem_wlen_q;
        mem_start_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        owner_d     = owner_q;
        terr_d      = terr_q;
`ifdef SDRAM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    mem_addr_d  = winner ? addr1 : addr0;
                    mem_wdata_d = winner ? wdata1 : wdata0;
                    mem_wlen_d  = winner ? len1 : len0;
                    owner_d     = winner;
                    mem_start_d = 1'b1;
                    state_d     = ST_ISSUE;
`ifdef SDRAM_ARB_RR_EN
                    last_d      = winner;
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A done in the terminal-count cycle wins over the watchdog.
                if (mem_done || cnt_q == TERM_CNT) begin
                    if (mem_done && mem_wlen_q == 2'b00) begin
                        if (owner_q) rdata1_d = mem_rdata;
                        else         rdata0_d = mem_rdata;
                    end
                    if (!mem_done) terr_d = 1'b1;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            mem_addr_q  <= 26'd0;
            mem_wdata_q <= 32'd0;
            mem_wlen_q  <= 2'b00;
            mem_start_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
            owner_q     <= 1'b0;
            terr_q      <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wlen_q  <= mem_wlen_d;
            mem_start_q <= mem_start_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            owner_q     <= owner_d;
            terr_q      <= terr_d;
`ifdef SDRAM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wlen    = mem_wlen_q;
    assign mem_start   = mem_start_q;
    assign busy        = (state_q != ST_IDLE);
    assign owner       = owner_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
// Expectations follow SDRAM_ARB_RR_EN when defined for the build.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  len0, len1;
    logic [25:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [25:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_wlen;
    logic        mem_start;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        busy, owner, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_rd0 = 32'd0;
    logic [31:0] exp_rd1 = 32'd0;
    int ack1_seen;
    logic exp_own;

    sdram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wlen(mem_wlen),
        .mem_start(mem_start), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access from cycle 0; mem_done in cycle done_cyc; returns in the ack cycle.
    task automatic access(input logic port, input logic [1:0] len, input logic [25:0] addr,
                          input logic [31:0] wd, input int done_cyc, input logic [31:0] rd,
                          input logic keep);
        if (!port) begin req0 = 1'b1; len0 = len; addr0 = addr; wdata0 = wd; end
        else       begin req1 = 1'b1; len1 = len; addr1 = addr; wdata1 = wd; end
        tick;
        chk("start", mem_start, 1'b1);
        chk("mem_addr", mem_addr, addr);
        chk("mem_wlen", mem_wlen, len);
        if (len != 2'b00) chk("mem_wdata", mem_wdata, wd);
        chk("owner", owner, port);
        for (int c = 2; c <= done_cyc; c++) begin
            tick;
            chk("early_ack", ack0 | ack1, 1'b0);
            if (c == done_cyc) begin mem_done = 1'b1; mem_rdata = rd; end
        end
        tick;
        mem_done  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        chk("ack_own", port ? ack1 : ack0, 1'b1);
        chk("ack_other", port ? ack0 : ack1, 1'b0);
        chk("busy_ack", busy, 1'b0);
        if (len == 2'b00) begin
            if (port) exp_rd1 = rd; else exp_rd0 = rd;
        end
        chk("rdata0", rdata0, exp_rd0);
        chk("rdata1", rdata1, exp_rd1);
        if (!keep) begin
            if (port) req1 = 1'b0; else req0 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; len0 = 2'b00; len1 = 2'b00;
        addr0 = 26'd0; addr1 = 26'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        mem_done = 1'b0; mem_rdata = 32'd0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", mem_start, 1'b0);
        chk("rst_ack", {ack1, ack0}, 2'b00);
        chk("rst_owner", owner, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        tick;
        rst = 1'b0;

        // single read, done in cycle 4, ack in cycle 5
        access(1'b0, 2'b00, 26'h0001234, 32'h0, 4, 32'hCAFE0123, 1'b0);
        // single write on port 1
        access(1'b1, 2'b11, 26'h0000444, 32'h12345678, 3, 32'h55AA55AA, 1'b0);

        // ack masking: req0 stays high through and after the ack cycle
        access(1'b0, 2'b01, 26'h0000010, 32'h000000A5, 2, 32'h0, 1'b1);
        tick;
        chk("mask_busy", busy, 1'b0);
        chk("mask_start", mem_start, 1'b0);
        tick;
        chk("regrant_start", mem_start, 1'b1);
        chk("regrant_owner", owner, 1'b0);
        tick;
        mem_done = 1'b1;
        tick;
        mem_done = 1'b0;
        chk("regrant_ack0", ack0, 1'b1);
        req0 = 1'b0;
        tick;

        // back-to-back: port 1 waits and is granted in the ack0 cycle
        req0 = 1'b1; len0 = 2'b00; addr0 = 26'h0000100;
        tick;
        chk("b2b_owner0", owner, 1'b0);
        req1 = 1'b1; len1 = 2'b00; addr1 = 26'h0000200;
        tick;
        mem_done = 1'b1; mem_rdata = 32'h0BADF00D;
        tick;
        mem_done = 1'b0;
        chk("b2b_ack0", ack0, 1'b1);
        exp_rd0 = 32'h0BADF00D;
        chk("b2b_rdata0", rdata0, exp_rd0);
        req0 = 1'b0;
        tick;
        chk("b2b_start1", mem_start, 1'b1);
        chk("b2b_owner1", owner, 1'b1);
        chk("b2b_addr1", mem_addr, 26'h0000200);
        tick;
        mem_done = 1'b1; mem_rdata = 32'h13572468;
        tick;
        mem_done = 1'b0;
        chk("b2b_ack1", ack1, 1'b1);
        exp_rd1 = 32'h13572468;
        chk("b2b_rdata1", rdata1, exp_rd1);
        req1 = 1'b0;
        tick;

        // simultaneous requests, four rounds of writes
        ack1_seen = 0;
        for (int r = 0; r < 4; r++) begin
            req0 = 1'b1; len0 = 2'b11; addr0 = 26'(r); wdata0 = 32'(r);
            req1 = 1'b1; len1 = 2'b11; addr1 = 26'(r + 16); wdata1 = 32'(r + 16);
`ifdef SDRAM_ARB_RR_EN
            exp_own = r[0];
`else
            exp_own = 1'b0;
`endif
            tick;
            chk("sim_start", mem_start, 1'b1);
            chk("sim_owner", owner, exp_own);
            chk("sim_addr", mem_addr, exp_own ? 26'(r + 16) : 26'(r));
            tick;
            mem_done = 1'b1;
            tick;
            mem_done = 1'b0;
            chk("sim_ack", {ack1, ack0}, exp_own ? 2'b10 : 2'b01);
            if (ack1) ack1_seen++;
            req0 = 1'b0; req1 = 1'b0;
            tick;
        end
`ifdef SDRAM_ARB_RR_EN
        chk("sim_ack1_count", 32'(ack1_seen), 32'd2);
`else
        chk("sim_ack1_count", 32'(ack1_seen), 32'd0);
`endif
        chk("sim_rdata1", rdata1, exp_rd1);

        // done in the terminal-count cycle is a normal completion
        access(1'b0, 2'b00, 26'h0003333, 32'h0, 9, 32'h77778888, 1'b0);
        chk("tc_terr", timeout_err, 1'b0);
        tick;

        // watchdog: no done, ack after 8 WAIT cycles
        req0 = 1'b1; len0 = 2'b00; addr0 = 26'h0002222;
        tick;
        for (int c = 2; c <= 9; c++) begin
            tick;
            chk("to_wait", {busy, ack0}, 2'b10);
        end
        tick;
        chk("to_ack0", ack0, 1'b1);
        chk("to_terr", timeout_err, 1'b1);
        chk("to_rdata0", rdata0, exp_rd0);
        req0 = 1'b0;
        tick;
        access(1'b1, 2'b00, 26'h0004444, 32'h0, 3, 32'hA1B2C3D4, 1'b0);
        chk("to_sticky", timeout_err, 1'b1);
        tick;

        // reset during WAIT
        req0 = 1'b1; len0 = 2'b00; addr0 = 26'h0005555;
        tick;
        tick;
        tick;
        req1 = 1'b1; len1 = 2'b00; addr1 = 26'h0006666;
        #2 rst = 1'b1;
        #1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_addr", mem_addr, 26'h0);
        chk("rw_terr", timeout_err, 1'b0);
        chk("rw_rdata", {rdata0, rdata1}, 64'h0);
        chk("rw_owner", owner, 1'b0);
        tick;
        tick;
        chk("rw_noack", {ack1, ack0}, 2'b00);
        rst = 1'b0;
        exp_rd0 = 32'd0;
        exp_rd1 = 32'd0;
        tick;
        chk("rw_start", mem_start, 1'b1);
        chk("rw_owner0", owner, 1'b0);
        tick;
        mem_done = 1'b1; mem_rdata = 32'h00C0FFEE;
        tick;
        mem_done = 1'b0;
        chk("rw_ack0", ack0, 1'b1);
        chk("rw_rdata0", rdata0, 32'h00C0FFEE);
        req0 = 1'b0;
        tick;
        chk("rw_owner1", owner, 1'b1);
        tick;
        mem_done = 1'b1; mem_rdata = 32'h00FACADE;
        tick;
        mem_done = 1'b0;
        chk("rw_ack1", ack1, 1'b1);
        chk("rw_rdata1", rdata1, 32'h00FACADE);
        req1 = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
